// File: rtl/resp_compactor_pkg.sv
// resp_compactor_pkg: shared types, constants and the MISR step function for
// the response compactor.
//   state_t     - FSM encoding (IDLE, COMPACT, COMPARE, DONE)
//   DEF_POLY    - default Galois feedback polynomial (x^16 implicit)
//   DEF_SEED    - default signature seed
//   misr_step() - one MISR update, generic up to MISR_MAX_W bits
package resp_compactor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;
    localparam int          MISR_MAX_W = 64;

    // One Galois MISR step on a 'width'-bit signature held in the low bits of
    // a 64-bit word. 'data' must already be zero-extended. The feedback bit is
    // taken by shifting rather than by a variable bit-select, so the function
    // folds to plain XOR logic when 'width' is a constant.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] data,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] msb_word;
        logic [MISR_MAX_W-1:0] nxt;
        mask     = ~({MISR_MAX_W{1'b1}} << width);
        msb_word = (sig & mask) >> (width - 1);
        nxt      = (sig << 1) & mask;
        if (msb_word[0])
            nxt = nxt ^ poly;
        nxt = nxt ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/resp_compactor_misr.sv
// resp_compactor_misr (module misr_reg): signature register of the compactor.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (loads SEED)
//   load      - reload SEED (takes priority over en)
//   en        - compact 'data' into the signature this cycle
//   data      - response word, zero-extended into the LSBs
//   sig       - current signature
module misr_reg
    import resp_compactor_pkg::*;
#(
    parameter int               RESP_W = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [MISR_MAX_W-1:0] step_full;
    logic [SIG_W-1:0]      sig_next;

    always_comb begin
        step_full = misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(POLY),
                              MISR_MAX_W'(data), SIG_W);
        sig_next  = step_full[SIG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || load)
            sig <= SEED;
        else if (en)
            sig <= sig_next;
    end

endmodule

// File: rtl/resp_compactor.sv
// resp_compactor: output-response analyzer. Compacts NUM_PAT response words
// into a MISR, then compares the signature against 'golden'.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - begin a run (honoured only in IDLE or DONE)
//   resp_valid  - resp_data carries a response this cycle
//   resp_data   - DUT response word
//   golden      - expected signature, sampled in COMPARE
//   busy        - state is COMPACT
//   done        - state is DONE
//   pass        - result of last compare, valid while done=1
//   signature   - current MISR contents
//   count       - responses accepted in the current run
module resp_compactor
    import resp_compactor_pkg::*;
#(
    parameter int               RESP_W  = 1,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
    parameter int               NUM_PAT = 4,
    localparam int              CNT_W   = $clog2(NUM_PAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  golden,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    state_t state, state_next;
    logic   start_ok;
    logic   accept;
    logic   last;

    // start in COMPACT/COMPARE is dropped; response data is only taken in
    // COMPACT, which also excludes the start cycle itself.
    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept   = (state == COMPACT) && resp_valid;
    assign last     = accept && (count == CNT_W'(NUM_PAT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COMPACT;
            COMPACT: if (last)     state_next = COMPARE;
            COMPARE:               state_next = DONE;
            DONE:    if (start_ok) state_next = COMPACT;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            count <= '0;
        else if (accept)
            count <= count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            pass <= 1'b0;
        else if (state == COMPARE)
            pass <= (signature == golden);
    end

    misr_reg #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (accept),
        .data (resp_data),
        .sig  (signature)
    );

    assign busy = (state == COMPACT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_resp_compactor.sv
// tb_resp_compactor: directed self-checking bench for resp_compactor with
// hand-computed MISR signatures (POLY=16'h1021, SEED=16'hFFFF, NUM_PAT=4).
module tb_resp_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        resp_valid;
    logic [0:0]  resp_data;
    logic [15:0] golden;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    resp_compactor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .golden     (golden),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .count      (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sig"},   32'(signature), 32'hFFFF);
        check({tag, "_count"}, 32'(count),     32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_pass"},  32'(pass),      32'd0);
    endtask

    // Full run: start, four responses (bits[0] first) with 'stalls' idle
    // cycles between them, then compare. e0..e3 are expected signatures.
    task automatic run(input string tag, input logic [3:0] bits,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3,
                       input int stalls, input logic exp_pass);
        logic [15:0] exp_sig [4];
        exp_sig[0] = e0; exp_sig[1] = e1; exp_sig[2] = e2; exp_sig[3] = e3;
        start      = 1'b1;
        resp_valid = 1'b1;          // must be ignored in the start cycle
        resp_data  = 1'b1;
        step();
        start      = 1'b0;
        resp_valid = 1'b0;
        check({tag, "_start_busy"}, 32'(busy),      32'd1);
        check({tag, "_start_done"}, 32'(done),      32'd0);
        check({tag, "_start_sig"},  32'(signature), 32'hFFFF);
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp_data  = bits[i];
            step();
            resp_valid = 1'b0;
            check($sformatf("%s_sig%0d", tag, i), 32'(signature), 32'(exp_sig[i]));
            check($sformatf("%s_cnt%0d", tag, i), 32'(count),     32'(i + 1));
            if (i < 3) begin
                for (int s = 0; s < stalls; s++) begin
                    step();
                    check($sformatf("%s_stall_cnt%0d_%0d", tag, i, s), 32'(count), 32'(i + 1));
                end
            end
        end
        check({tag, "_cmp_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmp_done"}, 32'(done), 32'd0);
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 1'b0;
        golden     = 16'h0E17;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        step();
        check_reset("idle");

        // Golden pass
        run("gold", 4'b0001, 16'hEFDE, 16'hCF9D, 16'h8F1B, 16'h0E17, 0, 1'b1);

        // resp_valid in DONE leaves signature untouched
        resp_valid = 1'b1;
        resp_data  = 1'b1;
        step();
        resp_valid = 1'b0;
        check("done_rv_sig",  32'(signature), 32'h0E17);
        check("done_rv_done", 32'(done),      32'd1);
        check("done_rv_pass", 32'(pass),      32'd1);

        // Single-bit error, started from the first DONE cycle of... a fresh
        // DONE state (back-to-back start is exercised below)
        run("err", 4'b0101, 16'hEFDE, 16'hCF9D, 16'h8F1A, 16'h0E15, 0, 1'b0);

        // Back-to-back: start in the first DONE cycle after a run
        run("b2b", 4'b0001, 16'hEFDE, 16'hCF9D, 16'h8F1B, 16'h0E17, 0, 1'b1);

        // Stalls of 3 cycles between responses
        run("stall", 4'b0001, 16'hEFDE, 16'hCF9D, 16'h8F1B, 16'h0E17, 3, 1'b1);

        // start pulsed mid-COMPACT is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1;
            resp_data  = (i == 0) ? 1'b1 : 1'b0;
            step();
        end
        resp_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("midstart_busy",  32'(busy),      32'd1);
        check("midstart_count", 32'(count),     32'd2);
        check("midstart_sig",   32'(signature), 32'hCF9D);

        // Reset mid-run (2 responses accepted)
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("midrst");

        run("fresh", 4'b0001, 16'hEFDE, 16'hCF9D, 16'h8F1B, 16'h0E17, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
